cp0_regfile: RTL and testbench
==============================

# cp0_regfile

Coprocessor-0 register file for the SimpleMIPS core, downstream of the WB-stage exception control. Consumes the CP0 write port, ERET flush and packed exception record produced at writeback. Holds BadVAddr, Count, Compare, Status, Cause and EPC, and returns read data for MFC0. Supplies EPC to the fetch redirect and an interrupt-pending flag to the pipeline.

## Interface
- `STATUS_BEV_RST`, default 1: reset value of Status.BEV (bit 22).
- `clk`  in  1  core clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `c0_we`  in  1  MTC0 commit strobe.
- `c0_addr`  in  8  {rd[4:0], sel[2:0]}; shared read/write address.
- `c0_wdata`  in  32  MTC0 data.
- `c0_rdata`  out  32  MFC0 read data; combinational from `c0_addr`.
- `c0_eret_flush`  in  1  ERET committed this cycle.
- `c0_exception`  in  exception_t  {bd, ex, exccode[4:0], badvaddr[31:0]}.
- `c0_pc`  in  virt_t  PC of the committing instruction.
- `ext_int`  in  6  hardware interrupt lines, level-sensitive.
- `c0_epc`  out  32  current EPC, for the ERET redirect.
- `c0_status_exl`  out  1  Status.EXL.
- `has_int`  out  1  interrupt pending and enabled.

## Operation
- Address decode (sel=0 only; anything else reads 0, writes ignored): BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14.
- Status writable bits:
  - IM[15:8], EXL[1] and IE[0] are written by MTC0.
  - BEV[22] is read-only at its reset value.
  - All other bits read 0.
- Cause fields:
  - BD[31] and TI[30] are read-only.
  - IP[15:10] is hardware: IP7 = ext_int[5] | TI; IP6..IP2 = ext_int[4:0].
  - IP[9:8] are software bits, writable.
  - ExcCode[6:2] is hardware-only.
  - All other bits read 0.
- EPC: fully writable. BadVAddr: read-only.
- Exception (`c0_exception.ex`=1):
  - If EXL=0: EPC ← bd ? c0_pc−4 : c0_pc, and Cause.BD ← bd.
  - If EXL=1: EPC and BD are unchanged.
  - In both cases: EXL ← 1 and ExcCode ← exccode.
  - BadVAddr ← badvaddr only for exccode 4 (AdEL) or 5 (AdES).
- ERET (`c0_eret_flush`=1, ex=0): EXL ← 0.
- Timer:
  - A 1-bit `tick` toggles every cycle.
  - Count increments (mod 2^32) on cycles where tick=1.
  - TI is set when Count == Compare.
  - An MTC0 write to Compare clears TI.
- `has_int` = |(Cause.IP & Status.IM) & IE & ~EXL.

## Timing
- Reset values:
  - Status = STATUS_BEV_RST<<22.
  - Cause, EPC, BadVAddr, Count, Compare all 0; tick = 0.
  - Hence `has_int`=0, `c0_epc`=0, `c0_status_exl`=0.
- Reset is asynchronous and may assert mid-operation. All state returns to reset values immediately, with no partial writes.
- Read timing:
  - `c0_rdata` is zero-latency combinational.
  - A read in the same cycle as a write to the same address returns the old value; the new value is visible the next cycle.
- Write timing: MTC0, exception and ERET effects are visible one cycle after the strobe.
- Simultaneous events:
  - ex together with c0_we: the write is suppressed (the excepting instruction does not commit).
  - ex together with eret: the exception wins and EXL stays 1.
  - MTC0 to Count with a tick=1 edge: the written value wins.
  - Compare write with a Count==Compare match: the clear wins (TI=0).
- Count wraps 0xFFFF_FFFF → 0 without a flag.
- IP[15:10] are resampled from `ext_int`/TI every cycle. `has_int` lags `ext_int` by one cycle.

## Configuration
- `CP0_TIMER_EN` defined:
  - Count, Compare, tick and TI are implemented as above.
- `CP0_TIMER_EN` undefined:
  - No Count/Compare flops.
  - Addresses 9 and 11 read 0 and ignore writes.
  - TI reads 0, so IP7 = ext_int[5].

## Test plan
- Reset, then read Status → 0x0040_0000. Read Cause/EPC → 0. `has_int`=0.
- Exception with exccode=4, badvaddr=0x8000_0003, pc=0xBFC0_0100, bd=0, EXL=0:
  - Next cycle: EPC=0xBFC0_0100, BadVAddr=0x8000_0003, Cause[6:2]=4, EXL=1.
  - Repeat with bd=1 while EXL=1 → EPC unchanged, BD unchanged.
- Exception with exccode=8 and bd=1, pc=0xBFC0_0204 from EXL=0:
  - EPC=0xBFC0_0200, Cause.BD=1, BadVAddr unchanged.
  - Then ERET → EXL=0.
- MTC0 Status=0x0000_8001, ext_int=6'b100000:
  - `has_int`=1 after one cycle.
  - Raise EXL via exception → `has_int`=0.
  - ex and c0_we to EPC in the same cycle → EPC takes the exception value, not wdata.
- With `CP0_TIMER_EN`: MTC0 Compare=5, Count=0:
  - TI=1 and Cause[30]=1 about 10 cycles later.
  - MTC0 Compare=5 again → TI=0.
  - MTC0 Count=0xFFFF_FFFF → wraps to 0 two cycles later.

Source files
------------

// File: rtl/cp0_regfile.sv
// rtl/cp0_regfile.sv - SimpleMIPS CP0 register file; Count/Compare timer enabled by CP0_TIMER_EN
package cp0_pkg;
    typedef struct packed {
        logic        bd;
        logic        ex;
        logic [4:0]  exccode;
        logic [31:0] badvaddr;
    } exception_t;
    typedef logic [31:0] virt_t;
endpackage

module cp0_regfile
    import cp0_pkg::*;
#(
    parameter logic STATUS_BEV_RST = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        c0_we,
    input  logic [7:0]  c0_addr,
    input  logic [31:0] c0_wdata,
    output logic [31:0] c0_rdata,
    input  logic        c0_eret_flush,
    input  exception_t  c0_exception,
    input  virt_t       c0_pc,
    input  logic [5:0]  ext_int,
    output logic [31:0] c0_epc,
    output logic        c0_status_exl,
    output logic        has_int
);
    localparam logic [4:0] RD_BADVADDR = 5'd8;
    localparam logic [4:0] RD_COUNT    = 5'd9;
    localparam logic [4:0] RD_COMPARE  = 5'd11;
    localparam logic [4:0] RD_STATUS   = 5'd12;
    localparam logic [4:0] RD_CAUSE    = 5'd13;
    localparam logic [4:0] RD_EPC      = 5'd14;

    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d, badvaddr_q, badvaddr_d;
    logic        ti;

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic        tick_q, tick_d, ti_q, ti_d;
    assign ti = ti_q;
`else
    assign ti = 1'b0;
`endif

    logic [4:0] rd;
    logic       sel_ok, wr;
    logic [31:0] status_w, cause_w;

    assign rd     = c0_addr[7:3];
    assign sel_ok = (c0_addr[2:0] == 3'd0);
    // an excepting instruction never commits its MTC0
    assign wr     = c0_we & ~c0_exception.ex & sel_ok;

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_sw_d    = ip_sw_q;
        exccode_d  = exccode_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        ip_hw_d    = {ext_int[5] | ti, ext_int[4:0]};

        if (wr) begin
            case (rd)
                RD_STATUS: begin
                    im_d  = c0_wdata[15:8];
                    exl_d = c0_wdata[1];
                    ie_d  = c0_wdata[0];
                end
                RD_CAUSE: ip_sw_d = c0_wdata[9:8];
                RD_EPC:   epc_d   = c0_wdata;
                default: ;
            endcase
        end

`ifdef CP0_TIMER_EN
        tick_d    = ~tick_q;
        count_d   = tick_q ? count_q + 32'd1 : count_q;
        compare_d = compare_q;
        ti_d      = ti_q | (count_q == compare_q);
        if (wr && rd == RD_COUNT) count_d = c0_wdata;
        if (wr && rd == RD_COMPARE) begin
            compare_d = c0_wdata;
            ti_d      = 1'b0;
        end
`endif

        if (c0_exception.ex) begin
            // nested exceptions keep the original return point
            if (!exl_q) begin
                epc_d = c0_exception.bd ? c0_pc - 32'd4 : c0_pc;
                bd_d  = c0_exception.bd;
            end
            exl_d     = 1'b1;
            exccode_d = c0_exception.exccode;
            if (c0_exception.exccode == 5'd4 || c0_exception.exccode == 5'd5)
                badvaddr_d = c0_exception.badvaddr;
        end else if (c0_eret_flush) begin
            exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_hw_q    <= '0;
            ip_sw_q    <= '0;
            exccode_q  <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
            exccode_q  <= exccode_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

`ifdef CP0_TIMER_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q   <= '0;
            compare_q <= '0;
            tick_q    <= 1'b0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            tick_q    <= tick_d;
            ti_q      <= ti_d;
        end
    end
`endif

    assign status_w = {9'd0, STATUS_BEV_RST, 6'd0, im_q, 6'd0, exl_q, ie_q};
    assign cause_w  = {bd_q, ti, 14'd0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b00};

    always_comb begin
        c0_rdata = '0;
        if (sel_ok) begin
            case (rd)
                RD_BADVADDR: c0_rdata = badvaddr_q;
`ifdef CP0_TIMER_EN
                RD_COUNT:    c0_rdata = count_q;
                RD_COMPARE:  c0_rdata = compare_q;
`endif
                RD_STATUS:   c0_rdata = status_w;
                RD_CAUSE:    c0_rdata = cause_w;
                RD_EPC:      c0_rdata = epc_q;
                default:     c0_rdata = '0;
            endcase
        end
    end

    assign c0_epc        = epc_q;
    assign c0_status_exl = exl_q;
    assign has_int       = (|({ip_hw_q, ip_sw_q} & im_q)) & ie_q & ~exl_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// tb/tb_cp0_regfile.sv - bench for cp0_regfile; timer checks follow CP0_TIMER_EN
module tb_cp0_regfile;
    import cp0_pkg::*;

    localparam logic [7:0] BV = 8'd64;
    localparam logic [7:0] CN = 8'd72;
    localparam logic [7:0] CM = 8'd88;
    localparam logic [7:0] ST = 8'd96;
    localparam logic [7:0] CA = 8'd104;
    localparam logic [7:0] EP = 8'd112;

    logic        clk = 1'b0;
    logic        resetn;
    logic        c0_we;
    logic [7:0]  c0_addr;
    logic [31:0] c0_wdata;
    logic [31:0] c0_rdata;
    logic        c0_eret_flush;
    exception_t  c0_exception;
    virt_t       c0_pc;
    logic [5:0]  ext_int;
    logic [31:0] c0_epc;
    logic        c0_status_exl;
    logic        has_int;

    int n_tests = 0;
    int n_fail  = 0;

    cp0_regfile dut (
        .clk           (clk),
        .resetn        (resetn),
        .c0_we         (c0_we),
        .c0_addr       (c0_addr),
        .c0_wdata      (c0_wdata),
        .c0_rdata      (c0_rdata),
        .c0_eret_flush (c0_eret_flush),
        .c0_exception  (c0_exception),
        .c0_pc         (c0_pc),
        .ext_int       (ext_int),
        .c0_epc        (c0_epc),
        .c0_status_exl (c0_status_exl),
        .has_int       (has_int)
    );

    always #5 clk = ~clk;

    // Architectural view: whole register words plus a cycle count since reset
    typedef struct {
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] badv;
        logic [31:0] count;
        logic [31:0] compare;
        int unsigned cyc;
    } model_t;

    model_t m;

    function automatic model_t m_reset();
        model_t r;
        r.status  = 32'h0040_0000;
        r.cause   = '0;
        r.epc     = '0;
        r.badv    = '0;
        r.count   = '0;
        r.compare = '0;
        r.cyc     = 0;
        return r;
    endfunction

    function automatic model_t m_step(model_t cur);
        model_t n = cur;
        logic [4:0] rd = c0_addr[7:3];
        logic wr = c0_we && !c0_exception.ex && (c0_addr[2:0] == 3'd0);
        logic ti = cur.cause[30];
`ifdef CP0_TIMER_EN
        if (cur.cyc % 2 == 1) n.count = cur.count + 32'd1;
        if (cur.count == cur.compare) ti = 1'b1;
        if (wr && rd == 5'd9) n.count = c0_wdata;
        if (wr && rd == 5'd11) begin
            n.compare = c0_wdata;
            ti = 1'b0;
        end
`endif
        n.cause[15:10] = {ext_int[5] | cur.cause[30], ext_int[4:0]};
        if (wr) begin
            case (rd)
                5'd12: n.status = (cur.status & ~32'h0000_FF03) | (c0_wdata & 32'h0000_FF03);
                5'd13: n.cause[9:8] = c0_wdata[9:8];
                5'd14: n.epc = c0_wdata;
                default: ;
            endcase
        end
        if (c0_exception.ex) begin
            if (!cur.status[1]) begin
                n.epc = c0_exception.bd ? c0_pc - 32'd4 : c0_pc;
                n.cause[31] = c0_exception.bd;
            end
            n.status[1] = 1'b1;
            n.cause[6:2] = c0_exception.exccode;
            if (c0_exception.exccode == 5'd4 || c0_exception.exccode == 5'd5)
                n.badv = c0_exception.badvaddr;
        end else if (c0_eret_flush) begin
            n.status[1] = 1'b0;
        end
        n.cause[30] = ti;
        n.cyc = cur.cyc + 1;
        return n;
    endfunction

    function automatic logic [31:0] m_read(model_t cur, logic [7:0] a);
        if (a[2:0] != 3'd0) return 32'd0;
        case (a[7:3])
            5'd8:  return cur.badv;
`ifdef CP0_TIMER_EN
            5'd9:  return cur.count;
            5'd11: return cur.compare;
`endif
            5'd12: return cur.status;
            5'd13: return cur.cause;
            5'd14: return cur.epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_has_int(model_t cur);
        return (|(cur.cause[15:8] & cur.status[15:8])) && cur.status[0] && !cur.status[1];
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) m <= m_reset();
        else         m <= m_step(m);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_rdata", c0_rdata, m_read(m, c0_addr));
        chk("model_epc", c0_epc, m.epc);
        chk("model_exl", {31'd0, c0_status_exl}, {31'd0, m.status[1]});
        chk("model_has_int", {31'd0, has_int}, {31'd0, m_has_int(m)});
    end

    task automatic step();
        @(posedge clk);
        #1;
        c0_we         = 1'b0;
        c0_eret_flush = 1'b0;
        c0_exception  = '0;
    endtask

    task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
        c0_we    = 1'b1;
        c0_addr  = a;
        c0_wdata = d;
        step();
    endtask

    task automatic raise(input logic bd, input logic [4:0] code, input logic [31:0] bva, input logic [31:0] pc);
        c0_exception = '{bd: bd, ex: 1'b1, exccode: code, badvaddr: bva};
        c0_pc        = pc;
    endtask

    task automatic rdchk(input string name, input logic [7:0] a, input logic [31:0] mask, input logic [31:0] exp);
        c0_addr = a;
        @(negedge clk);
        chk(name, c0_rdata & mask, exp);
        #1;
    endtask

    initial begin
        resetn        = 1'b1;
        c0_we         = 1'b0;
        c0_addr       = '0;
        c0_wdata      = '0;
        c0_eret_flush = 1'b0;
        c0_exception  = '0;
        c0_pc         = '0;
        ext_int       = '0;
        #1 resetn = 1'b0;
        c0_addr = ST; #1 chk("rst_status", c0_rdata, 32'h0040_0000);
        c0_addr = CA; #1 chk("rst_cause", c0_rdata, 32'h0);
        c0_addr = EP; #1 chk("rst_epc", c0_rdata, 32'h0);
        chk("rst_has_int", {31'd0, has_int}, 32'd0);
        chk("rst_exl", {31'd0, c0_status_exl}, 32'd0);
        #18 resetn = 1'b1;
        @(posedge clk); #1;

        raise(1'b0, 5'd4, 32'h8000_0003, 32'hBFC0_0100); step();
        chk("exl_after_ex", {31'd0, c0_status_exl}, 32'd1);
        rdchk("epc_adel", EP, 32'hFFFF_FFFF, 32'hBFC0_0100);
        rdchk("badv_adel", BV, 32'hFFFF_FFFF, 32'h8000_0003);
        rdchk("exccode_adel", CA, 32'h0000_007C, 32'h0000_0010);

        raise(1'b1, 5'd4, 32'h1111_1111, 32'h1234_5678); step();
        rdchk("epc_nested", EP, 32'hFFFF_FFFF, 32'hBFC0_0100);
        rdchk("bd_nested", CA, 32'h8000_0000, 32'h0);
        rdchk("badv_nested", BV, 32'hFFFF_FFFF, 32'h1111_1111);
        c0_eret_flush = 1'b1; step();
        chk("exl_eret1", {31'd0, c0_status_exl}, 32'd0);

        raise(1'b1, 5'd8, 32'h9999_9999, 32'hBFC0_0204); step();
        rdchk("epc_bd", EP, 32'hFFFF_FFFF, 32'hBFC0_0200);
        rdchk("cause_bd", CA, 32'h8000_007C, 32'h8000_0020);
        rdchk("badv_syscall", BV, 32'hFFFF_FFFF, 32'h1111_1111);
        c0_eret_flush = 1'b1; step();
        chk("exl_eret2", {31'd0, c0_status_exl}, 32'd0);

        ext_int = 6'b010000;
        mtc0(ST, 32'h0000_4001);
        chk("has_int_ip6", {31'd0, has_int}, 32'd1);
        ext_int = 6'b000000; #1;
        chk("has_int_lag", {31'd0, has_int}, 32'd1);
        step();
        chk("has_int_drop", {31'd0, has_int}, 32'd0);

        ext_int = 6'b100000;
        mtc0(ST, 32'h0000_8001);
        chk("has_int_ip7", {31'd0, has_int}, 32'd1);
        rdchk("status_rw", ST, 32'hFFFF_FFFF, 32'h0040_8001);
        raise(1'b0, 5'd0, 32'h0, 32'h8000_0180); step();
        chk("has_int_exl", {31'd0, has_int}, 32'd0);
        c0_eret_flush = 1'b1; step();
        chk("has_int_back", {31'd0, has_int}, 32'd1);
        raise(1'b0, 5'd0, 32'h0, 32'h8000_1000);
        c0_eret_flush = 1'b1;
        mtc0(EP, 32'hDEAD_BEEF);
        chk("epc_ex_vs_we", c0_epc, 32'h8000_1000);
        chk("exl_ex_vs_eret", {31'd0, c0_status_exl}, 32'd1);

        mtc0(EP | 8'd1, 32'h0000_5555);
        rdchk("epc_sel1_ignored", EP, 32'hFFFF_FFFF, 32'h8000_1000);
        rdchk("sel1_reads0", EP | 8'd1, 32'hFFFF_FFFF, 32'h0);
        mtc0(ST, 32'hFFFF_FFFF);
        rdchk("status_mask", ST, 32'hFFFF_FFFF, 32'h0040_FF03);
        mtc0(CA, 32'hFFFF_FFFF);
        rdchk("cause_sw_ip", CA, 32'h0000_0300, 32'h0000_0300);
        mtc0(BV, 32'h0);
        rdchk("badv_ro", BV, 32'hFFFF_FFFF, 32'h1111_1111);

`ifdef CP0_TIMER_EN
        mtc0(CM, 32'd5);
        mtc0(CN, 32'd0);
        repeat (14) @(posedge clk);
        #1;
        rdchk("ti_set", CA, 32'h4000_0000, 32'h4000_0000);
        mtc0(CM, 32'd5);
        rdchk("ti_clear", CA, 32'h4000_0000, 32'h0);
        rdchk("compare_rd", CM, 32'hFFFF_FFFF, 32'd5);
        mtc0(CN, 32'hFFFF_FFFF);
        c0_addr = CN;
        @(posedge clk); @(posedge clk); #1;
        chk("count_wrap", c0_rdata, 32'h0);
`else
        mtc0(CN, 32'h0000_1234);
        mtc0(CM, 32'h0000_1234);
        rdchk("count_absent", CN, 32'hFFFF_FFFF, 32'h0);
        rdchk("compare_absent", CM, 32'hFFFF_FFFF, 32'h0);
`endif

        @(posedge clk); #3 resetn = 1'b0;
        c0_addr = ST; #1;
        chk("midrst_status", c0_rdata, 32'h0040_0000);
        chk("midrst_epc", c0_epc, 32'h0);
        chk("midrst_exl", {31'd0, c0_status_exl}, 32'd0);
        chk("midrst_has_int", {31'd0, has_int}, 32'd0);
        #12 resetn = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
